// File: rtl/imem_loadable.sv
// imem_loadable: instruction memory loaded byte-serially at run time, with a registered req/valid fetch port.
// Define IMEM_MISALIGN_TRAP_EN to add misalign_err and NOP substitution for unaligned fetches.
module imem_loadable #(
    parameter int unsigned DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_start,
    input  logic [$clog2(DEPTH):0] load_len,
    input  logic                   load_byte_valid,
    input  logic [7:0]             load_byte,
    output logic                   loading,
    output logic                   load_done,
    input  logic                   fetch_req,
    input  logic [31:0]            fetch_addr,
    output logic                   fetch_valid,
    output logic [31:0]            instruction
`ifdef IMEM_MISALIGN_TRAP_EN
    ,
    output logic                   misalign_err
`endif
);
    localparam int unsigned      ADDR_W    = $clog2(DEPTH);
    localparam int unsigned      LEN_W     = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   ptr_q, ptr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [23:0]        buf_q, buf_d;
    logic               mem_we_s;
    logic [31:0]        mem_q [DEPTH] = '{default: NOP_WORD};

    logic               serve_s;
    logic               oor_s;
    logic               mis_s;
    logic [ADDR_W-1:0]  idx_s;
    logic               fetch_valid_q, fetch_valid_d;
    logic [31:0]        instr_q, instr_d;

    // Load FSM state and byte/word counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            len_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= 2'd0;
            buf_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // Load FSM next state; bytes shift into buf_q and the 4th byte completes the word write
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        mem_we_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    len_d   = (load_len > DEPTH_LEN) ? DEPTH_LEN : load_len;
                    ptr_d   = '0;
                    cnt_d   = 2'd0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (ptr_q == len_q) begin
                    state_d = ST_DONE;
                end else if (load_byte_valid) begin
                    if (cnt_q == 2'd3) begin
                        mem_we_s = 1'b1;
                        ptr_d    = ptr_q + LEN_W'(1);
                        cnt_d    = 2'd0;
                        state_d  = (ptr_q + LEN_W'(1) == len_q) ? ST_DONE : ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                        buf_d = {buf_q[15:0], load_byte};
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Memory array write port; deliberately not reset so loaded words survive a reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[ptr_q[ADDR_W-1:0]] <= {buf_q, load_byte};
        end
    end

    assign idx_s = fetch_addr[ADDR_W+1:2];

`ifdef IMEM_MISALIGN_TRAP_EN
    assign mis_s = (fetch_addr[1:0] != 2'b00);
`else
    logic unused_addr_s;
    assign unused_addr_s = ^fetch_addr[1:0];
    assign mis_s         = 1'b0;
`endif

    // Fetch next state: fetches are blocked only while loading
    always_comb begin
        serve_s       = fetch_req && (state_q != ST_LOAD);
        oor_s         = (fetch_addr[31:2] >= 30'(DEPTH));
        fetch_valid_d = serve_s;
        if (serve_s && (oor_s || mis_s)) begin
            instr_d = NOP_WORD;
        end else if (serve_s) begin
            instr_d = mem_q[idx_s];
        end else begin
            instr_d = instr_q;
        end
    end

    // Fetch output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_valid_q <= 1'b0;
            instr_q       <= NOP_WORD;
        end else begin
            fetch_valid_q <= fetch_valid_d;
            instr_q       <= instr_d;
        end
    end

`ifdef IMEM_MISALIGN_TRAP_EN
    logic misalign_q;

    // Misalignment flag, raised only alongside the fetch it refers to
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= serve_s && mis_s;
        end
    end

    assign misalign_err = misalign_q;
`endif

    assign loading     = (state_q == ST_LOAD);
    assign load_done   = (state_q == ST_DONE);
    assign fetch_valid = fetch_valid_q;
    assign instruction = instr_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: directed vector table, hand-written load/abort sequences,
// and randomized fetch/load traffic checked against a word-array reference model.
module tb_imem_loadable;
    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h00000000;
`ifdef IMEM_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        load_start;
    logic [8:0]  load_len;
    logic        load_byte_valid;
    logic [7:0]  load_byte;
    logic        loading;
    logic        load_done;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] instruction;
`ifdef IMEM_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    imem_loadable dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .load_start      (load_start),
        .load_len        (load_len),
        .load_byte_valid (load_byte_valid),
        .load_byte       (load_byte),
        .loading         (loading),
        .load_done       (load_done),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_valid     (fetch_valid),
        .instruction     (instruction)
`ifdef IMEM_MISALIGN_TRAP_EN
        ,
        .misalign_err    (misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic        exp_mis;
    } vec_t;

    vec_t        vecs[14];
    logic [31:0] mem_model [DEPTH];
    logic [7:0]  bytes_q[$];
    logic [31:0] exp_instr;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if ((a >> 2) >= 32'(DEPTH)) return NOP;
        if (MIS_EN && (a[1:0] != 2'b00)) return NOP;
        return mem_model[int'(a >> 2)];
    endfunction

    // Feed every byte in bytes_q as a load of `len` words; optional idle gaps and a fetch held high.
    task automatic run_load(input int len, input bit gaps, input bit hold_fetch);
        int eff;
        int total;
        int i;
        eff   = (len > DEPTH) ? DEPTH : len;
        total = eff * 4;
        i     = 0;
        load_start      = 1'b1;
        load_len        = 9'(len);
        load_byte_valid = 1'b1;
        load_byte       = 8'hEE;
        tick;
        load_start = 1'b0;
        check("loading_after_start", {31'd0, loading}, 32'd1);
        fetch_req  = hold_fetch;
        fetch_addr = 32'h0;
        while (i < total) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                load_byte_valid = 1'b0;
            end else begin
                load_byte_valid = 1'b1;
                load_byte       = bytes_q[i];
                i++;
            end
            load_start = (i == 5);
            load_len   = 9'd1;
            tick;
            load_start = 1'b0;
            if (i == total) begin
                check("load_done_after_last", {31'd0, load_done}, 32'd1);
                check("loading_after_last", {31'd0, loading}, 32'd0);
            end else begin
                check("loading_mid", {31'd0, loading}, 32'd1);
                check("load_done_mid", {31'd0, load_done}, 32'd0);
            end
            if (hold_fetch) check("fetch_blocked", {31'd0, fetch_valid}, 32'd0);
        end
        load_byte_valid = 1'b0;
        fetch_req       = 1'b0;
        tick;
        check("load_done_pulse_end", {31'd0, load_done}, 32'd0);
        check("loading_end", {31'd0, loading}, 32'd0);
        for (int w = 0; w < eff; w++) begin
            mem_model[w] = {bytes_q[4*w], bytes_q[4*w+1], bytes_q[4*w+2], bytes_q[4*w+3]};
        end
    endtask

    task automatic rand_fetch(input int n);
        logic        req;
        logic [31:0] addr;
        int          r;
        for (int i = 0; i < n; i++) begin
            req = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 9);
            if (r < 6)      addr = 32'($urandom_range(0, 255)) << 2;
            else if (r < 8) addr = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
            else            addr = $urandom | 32'h00000400;
            fetch_req       = req;
            fetch_addr      = addr;
            load_byte_valid = 1'($urandom_range(0, 1));
            load_byte       = 8'($urandom);
            tick;
            if (req) exp_instr = ref_word(addr);
            check("rand_valid", {31'd0, fetch_valid}, {31'd0, req});
            check("rand_instr", instruction, exp_instr);
            check("rand_loading", {31'd0, loading}, 32'd0);
`ifdef IMEM_MISALIGN_TRAP_EN
            check("rand_mis", {31'd0, misalign_err}, {31'd0, req && (addr[1:0] != 2'b00)});
`endif
        end
        fetch_req       = 1'b0;
        load_byte_valid = 1'b0;
    endtask

    initial begin
        for (int w = 0; w < DEPTH; w++) mem_model[w] = NOP;
        exp_instr = NOP;
        vecs[0]  = '{1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 32'h00000000, 1'b1, 32'h2005003c, 1'b0};
        vecs[2]  = '{1'b1, 32'h00000004, 1'b1, 32'h8ca60000, 1'b0};
        vecs[3]  = '{1'b1, 32'h00000008, 1'b1, 32'h00000000, 1'b0};
        vecs[4]  = '{1'b0, 32'h00000004, 1'b0, 32'h00000000, 1'b0};
        vecs[5]  = '{1'b1, 32'h00000400, 1'b1, 32'h00000000, 1'b0};
        vecs[6]  = '{1'b1, 32'h00000004, 1'b1, 32'h8ca60000, 1'b0};
        vecs[7]  = '{1'b1, 32'hFFFFFFFC, 1'b1, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b1, 32'h00000000, 1'b1, 32'h2005003c, 1'b0};
        vecs[9]  = '{1'b0, 32'h00000000, 1'b0, 32'h2005003c, 1'b0};
        vecs[10] = '{1'b1, 32'h000003FC, 1'b1, 32'h00000000, 1'b0};
        vecs[11] = '{1'b1, 32'h00000006, 1'b1, MIS_EN ? 32'h00000000 : 32'h8ca60000, MIS_EN};
        vecs[12] = '{1'b1, 32'h00000002, 1'b1, MIS_EN ? 32'h00000000 : 32'h2005003c, MIS_EN};
        vecs[13] = '{1'b1, 32'h00000404, 1'b1, 32'h00000000, 1'b0};

        reset_n = 1'b0; load_start = 1'b0; load_len = 9'd0; load_byte_valid = 1'b0;
        load_byte = 8'h00; fetch_req = 1'b0; fetch_addr = 32'h0;
        repeat (2) tick;
        check("rst_loading", {31'd0, loading}, 32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_instruction", instruction, NOP);
        reset_n = 1'b1;
        tick;

        bytes_q = '{8'h20, 8'h05, 8'h00, 8'h3c, 8'h8c, 8'ha6, 8'h00, 8'h00};
        run_load(2, 1'b0, 1'b0);

        for (int v = 0; v < 14; v++) begin
            fetch_req  = vecs[v].req;
            fetch_addr = vecs[v].addr;
            tick;
            check($sformatf("vec%0d_valid", v), {31'd0, fetch_valid}, {31'd0, vecs[v].exp_valid});
            check($sformatf("vec%0d_instr", v), instruction, vecs[v].exp_instr);
`ifdef IMEM_MISALIGN_TRAP_EN
            check($sformatf("vec%0d_mis", v), {31'd0, misalign_err}, {31'd0, vecs[v].exp_mis});
`endif
        end
        fetch_req = 1'b0;

        // load_len=0 with a fetch in the same cycle: fetch served pre-load, then blocked in LOAD
        load_start = 1'b1; load_len = 9'd0; fetch_req = 1'b1; fetch_addr = 32'h4;
        tick;
        load_start = 1'b0; fetch_addr = 32'h0;
        check("len0_fetch_valid", {31'd0, fetch_valid}, 32'd1);
        check("len0_fetch_instr", instruction, mem_model[1]);
        check("len0_loading", {31'd0, loading}, 32'd1);
        tick;
        check("len0_blocked", {31'd0, fetch_valid}, 32'd0);
        check("len0_done", {31'd0, load_done}, 32'd1);
        tick;
        check("len0_done_served", {31'd0, fetch_valid}, 32'd1);
        check("len0_done_instr", instruction, mem_model[0]);
        check("len0_done_low", {31'd0, load_done}, 32'd0);
        fetch_req = 1'b0;

        bytes_q = '{8'hde, 8'had, 8'hbe, 8'hef};
        run_load(1, 1'b1, 1'b1);
        rand_fetch(150);

        // reset after 6 bytes of a 2-word load
        load_start = 1'b1; load_len = 9'd2;
        tick;
        load_start = 1'b0;
        bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 6; i++) begin
            load_byte_valid = 1'b1;
            load_byte       = bytes_q[i];
            tick;
        end
        load_byte_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("abort_loading", {31'd0, loading}, 32'd0);
        check("abort_load_done", {31'd0, load_done}, 32'd0);
        check("abort_instr", instruction, NOP);
        #1 reset_n = 1'b1;
        mem_model[0] = 32'h11223344;
        tick;
        check("abort_stays_run", {31'd0, loading}, 32'd0);
        fetch_req = 1'b1; fetch_addr = 32'h0;
        tick;
        check("abort_word0", instruction, mem_model[0]);
        fetch_addr = 32'h4;
        tick;
        check("abort_word1", instruction, mem_model[1]);
        check("abort_word1_valid", {31'd0, fetch_valid}, 32'd1);
        fetch_req = 1'b0;

        bytes_q.delete();
        for (int i = 0; i < 4 * DEPTH; i++) bytes_q.push_back(8'($urandom));
        run_load(300, 1'b1, 1'b0);
        rand_fetch(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
